// File: rtl/enemy_spawn_scheduler.sv
// Round-robin enemy spawner: issues one spawn request per cooldown period to free, enabled slots.
// Decision 1 cycle after cooldown expires; request holds until spawn_ack; game_active low aborts.
module enemy_spawn_scheduler #(
  parameter int N_ENEMY        = 23,
  parameter int SPAWN_INTERVAL = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               game_active,
  input  logic [N_ENEMY-1:0] enable_enemy,
  input  logic [N_ENEMY-1:0] enemy_kill,
  input  logic               spawn_ack,
  output logic               spawn_valid,
  output logic [4:0]         spawn_id,
  output logic [N_ENEMY-1:0] alive,
  output logic [4:0]         alive_count
);

  typedef enum logic [1:0] {IDLE, COOLDOWN, SPAWN} state_t;

  state_t             state, state_n;
  logic [7:0]         cnt, cnt_n;
  logic [4:0]         last_id, last_id_n, id_n;
  logic               valid_n;
  logic [N_ENEMY-1:0] alive_n;
  logic [N_ENEMY-1:0] cand;
  logic               found_hi;
  logic [4:0]         pick_hi, pick_lo, pick;

  assign cand = enable_enemy & ~alive;

  // Lowest candidate above last_id wins; otherwise wrap to the lowest candidate overall.
  always_comb begin
    found_hi = 1'b0;
    pick_hi  = '0;
    pick_lo  = '0;
    for (int i = N_ENEMY - 1; i >= 0; i--) begin
      if (cand[i]) begin
        pick_lo = 5'(i);
      end
      if (cand[i] && (5'(i) > last_id)) begin
        found_hi = 1'b1;
        pick_hi  = 5'(i);
      end
    end
    pick = found_hi ? pick_hi : pick_lo;
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    id_n      = spawn_id;
    valid_n   = spawn_valid;
    last_id_n = last_id;
    alive_n   = alive & enable_enemy & ~enemy_kill;
    if (!game_active) begin
      state_n = IDLE;
      valid_n = 1'b0;
      alive_n = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = COOLDOWN;
          cnt_n   = 8'd0;
        end
        COOLDOWN: begin
          if (cnt == 8'd0) begin
            if (|cand) begin
              id_n    = pick;
              valid_n = 1'b1;
              state_n = SPAWN;
            end
          end else if (tick) begin
            cnt_n = cnt - 8'd1;
          end
        end
        SPAWN: begin
          // Spawn overrides a same-cycle kill of the granted slot, but not a disable.
          if (spawn_ack) begin
            valid_n   = 1'b0;
            cnt_n     = 8'(SPAWN_INTERVAL);
            last_id_n = spawn_id;
            state_n   = COOLDOWN;
            if (enable_enemy[spawn_id]) begin
              alive_n[spawn_id] = 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      spawn_id    <= 5'd0;
      spawn_valid <= 1'b0;
      last_id     <= 5'(N_ENEMY - 1);
      alive       <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      spawn_id    <= id_n;
      spawn_valid <= valid_n;
      last_id     <= last_id_n;
      alive       <= alive_n;
    end
  end

  assign alive_count = 5'($countones(alive));

endmodule

// File: doc/enemy_spawn_scheduler.md
ENEMY_SPAWN_SCHEDULER -- requirements
Module: enemy_spawn_scheduler

Interface
REQ-001 Parameter N_ENEMY, default 23, number of enemy slots (slots 0-16 fly, 17-20 spider, 21-22 mosquito).
REQ-002 Parameter SPAWN_INTERVAL, default 3, ticks from grant acceptance to next spawn eligibility; legal range 1-255.
REQ-003 Port clk  input  1  single system clock; all state changes on rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port tick  input  1  one-cycle pulse per game time unit (e.g. frame); drives cooldown.
REQ-006 Port game_active  input  1  high while play is running.
REQ-007 Port enable_enemy  input  N_ENEMY  per-slot permission mask from the stage logic.
REQ-008 Port enemy_kill  input  N_ENEMY  one-cycle per-slot kill pulses from collision logic.
REQ-009 Port spawn_ack  input  1  enemy datapath accepts the current spawn request.
REQ-010 Port spawn_valid  output  1  spawn request pending.
REQ-011 Port spawn_id  output  5  slot index of the pending request.
REQ-012 Port alive  output  N_ENEMY  registered per-slot alive flags.
REQ-013 Port alive_count  output  5  population count of alive.

Function
REQ-014 Three states SHALL exist: IDLE, COOLDOWN, SPAWN.
REQ-015 Candidate set SHALL be enable_enemy AND NOT alive, evaluated each cycle.
REQ-016 IDLE: stays while game_active=0; on game_active=1 goes to COOLDOWN with counter = 0.
REQ-017 COOLDOWN: counter decrements by 1 on each tick while nonzero, saturating at 0.
REQ-018 COOLDOWN with counter=0 and non-empty candidate set SHALL, on that edge, select a slot, load spawn_id, set spawn_valid=1, enter SPAWN (one-cycle decision latency).
REQ-019 COOLDOWN with counter=0 and empty candidate set SHALL wait; no request issued.
REQ-020 Selection SHALL be round-robin: first candidate at or above last_id+1, wrapping N_ENEMY-1 -> 0; last_id updates to the granted slot on acceptance.
REQ-021 SPAWN: spawn_valid and spawn_id SHALL hold stable until spawn_ack=1 is sampled, even if enable_enemy changes.
REQ-022 On spawn_ack in SPAWN: alive[spawn_id] set on the next edge only if enable_enemy[spawn_id] is still 1; spawn_valid cleared; counter loaded with SPAWN_INTERVAL; state COOLDOWN.
REQ-023 spawn_ack outside SPAWN SHALL be ignored.
REQ-024 enemy_kill[i]=1 SHALL clear alive[i] next edge; kill of a non-alive slot ignored.
REQ-025 Kill and spawn acceptance on the same cycle for different slots SHALL both take effect; for the same slot, spawn takes priority (alive=1).
REQ-026 alive[i] SHALL be cleared whenever enable_enemy[i]=0 (despawn on disable), except REQ-025 does not override this.
REQ-027 game_active falling to 0 in any state SHALL, next edge: clear alive, clear spawn_valid (abort handshake), go IDLE; last_id retained.
REQ-028 tick during SPAWN SHALL not change the counter.
REQ-029 alive_count SHALL equal popcount(alive), combinational from the register, range 0-23.

Reset
REQ-030 On rst=1 at a clock edge: state=IDLE, spawn_valid=0, spawn_id=0, alive=0, counter=0, last_id=N_ENEMY-1 (so first grant searches from slot 0).
REQ-031 rst SHALL take priority over all other inputs, including mid-handshake; alive_count reads 0 the cycle after reset.

Verification
REQ-032 Reset, game_active=1, enable=0x1FFFF, ack held 1, tick every 4 cycles -> spawn_id sequence 0,1,2,... with grants spaced 3 ticks; alive_count increments 1 per grant up to 17, then no requests.
REQ-033 All 17 fly alive, enemy_kill[5] pulse -> alive[5]=0 next cycle, next grant after cooldown is slot 5; alive_count returns to 17.
REQ-034 spawn_valid=1, spawn_id=4, ack held 0 for 10 cycles while enable_enemy[4] drops -> valid/id stable all 10 cycles; on ack, alive[4] stays 0, state COOLDOWN.
REQ-035 Enable widens from 0x1FFFF to 0x7FFFFF with last_id=16 -> next grants 17,18,19,20,21,22, then wrap search starting at 0.
REQ-036 game_active dropped mid-SPAWN with alive_count=9 -> next cycle spawn_valid=0, alive=0, state IDLE; re-raise -> first grant at last_id+1 with no cooldown.
REQ-037 Same-cycle enemy_kill[3] and ack for spawn_id=3 -> alive[3]=1; same-cycle kill[2] and ack for id 7 -> alive[2]=0, alive[7]=1.
